exception_unit: RTL and testbench



---
 rtl/exception_unit_pkg.sv | 21 ++
 rtl/exception_unit_prio_enc.sv | 21 ++
 rtl/exception_unit.sv | 122 ++++++++++++
 tb/tb_exception_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_unit_pkg.sv
// Shared types and constants for the execute-stage exception unit.
// Holds the trap FSM state type and the fixed source index assignments.
package exception_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAPPED = 2'd1,
    RELEASE = 2'd2
  } excState_t;

  localparam int EXC_ALU_OVF  = 0;
  localparam int EXC_ILLEGAL  = 1;
  localparam int EXC_MISALIGN = 2;
  localparam int EXC_SW       = 3;

  // A single source still needs a one-bit cause field.
  function automatic int cause_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exception_unit_prio_enc.sv
// Multi-hot to lowest-set-index encoder; index 0 has the highest priority.
module exc_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scanning downwards lets the lowest set index overwrite the others.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/exception_unit.sv
// Exception capture and halt controller for the execute stage.
// Optional source mask enabled by defining EXCEPTION_UNIT_MASK_EN.
module exception_unit
  import exception_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 4,
  parameter int CAUSE_W = cause_width(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               instrValid_i,
  input  logic [NUM_SRC-1:0] excReq_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instruction_i,
  input  logic               excAck_i,
`ifdef EXCEPTION_UNIT_MASK_EN
  input  logic               maskWe_i,
  input  logic [NUM_SRC-1:0] maskIn_i,
`endif
  output logic               exception_o,
  output logic               halt_o,
  output logic [CAUSE_W-1:0] excCause_o,
  output logic [PC_W-1:0]    excPc_o,
  output logic [INSTR_W-1:0] excInstr_o,
  output logic [CNT_W-1:0]   excDropped_o
);

  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  excState_t          state_q;
  logic               halt_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   dropped_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] req_masked;
  logic [CAUSE_W-1:0] win_idx;
  logic               hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == DROP_MAX) ? v : v + 1'b1;
  endfunction

`ifdef EXCEPTION_UNIT_MASK_EN
  logic [NUM_SRC-1:0] mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '1;
    end else if (maskWe_i) begin
      mask_q <= maskIn_i;
    end
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign req_masked = excReq_i & mask & {NUM_SRC{instrValid_i}};

  exc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (CAUSE_W)
  ) u_prio_enc (
    .req_i   (req_masked),
    .idx_o   (win_idx),
    .valid_o (hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      halt_q    <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      instr_q   <= '0;
      dropped_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= TRAPPED;
            halt_q  <= 1'b1;
            cause_q <= win_idx;
            pc_q    <= pc_i;
            instr_q <= instruction_i;
          end
        end
        TRAPPED: begin
          if (hit) dropped_q <= sat_inc(dropped_q);
          if (excAck_i) begin
            state_q <= RELEASE;
            halt_q  <= 1'b0;
          end
        end
        // One dead cycle so the pipeline can flush the faulting instruction.
        RELEASE: begin
          state_q <= IDLE;
          halt_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational in the hit cycle so the PC update is suppressed immediately.
  assign exception_o  = ((state_q == IDLE) && hit) || halt_q;
  assign halt_o       = halt_q;
  assign excCause_o   = cause_q;
  assign excPc_o      = pc_q;
  assign excInstr_o   = instr_q;
  assign excDropped_o = dropped_q;

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit with a behavioural trap model.
module tb_exception_unit;

  localparam int NUM_SRC = 4;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              instrValid_i;
  logic [3:0]        excReq_i;
  logic [31:0]       pc_i;
  logic [31:0]       instruction_i;
  logic              excAck_i;
`ifdef EXCEPTION_UNIT_MASK_EN
  logic              maskWe_i;
  logic [3:0]        maskIn_i;
`endif
  logic              exception_o;
  logic              halt_o;
  logic [1:0]        excCause_o;
  logic [31:0]       excPc_o;
  logic [31:0]       excInstr_o;
  logic [3:0]        excDropped_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the trap protocol.
  bit          m_trapped;
  bit          m_release;
  int          m_cause;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int          m_drop;
  logic [3:0]  m_mask;

  exception_unit #(
    .NUM_SRC (NUM_SRC),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instrValid_i  (instrValid_i),
    .excReq_i      (excReq_i),
    .pc_i          (pc_i),
    .instruction_i (instruction_i),
    .excAck_i      (excAck_i),
`ifdef EXCEPTION_UNIT_MASK_EN
    .maskWe_i      (maskWe_i),
    .maskIn_i      (maskIn_i),
`endif
    .exception_o   (exception_o),
    .halt_o        (halt_o),
    .excCause_o    (excCause_o),
    .excPc_o       (excPc_o),
    .excInstr_o    (excInstr_o),
    .excDropped_o  (excDropped_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_hit();
    return instrValid_i && ((excReq_i & m_mask) != 4'b0000);
  endfunction

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic bit m_exception();
    return m_trapped || (!m_trapped && !m_release && m_hit());
  endfunction

  function automatic logic [1:0] m_cause_bits();
    return 2'(m_cause);
  endfunction

  task automatic model_reset();
    m_trapped = 0; m_release = 0; m_cause = 0;
    m_pc = '0; m_instr = '0; m_drop = 0; m_mask = 4'b1111;
  endtask

  // Advance one clock edge, updating the model from the inputs sampled there.
  task automatic tick();
    bit n_trapped = m_trapped;
    bit n_release = m_release;
    int n_cause = m_cause;
    logic [31:0] n_pc = m_pc;
    logic [31:0] n_instr = m_instr;
    int n_drop = m_drop;
    logic [3:0] n_mask = m_mask;
    if (m_release) begin
      n_release = 0;
    end else if (m_trapped) begin
      if (m_hit() && m_drop < (1 << CNT_W) - 1) n_drop = m_drop + 1;
      if (excAck_i) begin
        n_trapped = 0;
        n_release = 1;
      end
    end else if (m_hit()) begin
      n_trapped = 1;
      n_cause = lowest_set(excReq_i & m_mask);
      n_pc = pc_i;
      n_instr = instruction_i;
    end
`ifdef EXCEPTION_UNIT_MASK_EN
    if (maskWe_i) n_mask = maskIn_i;
`endif
    @(posedge clk_i);
    m_trapped = n_trapped; m_release = n_release; m_cause = n_cause;
    m_pc = n_pc; m_instr = n_instr; m_drop = n_drop; m_mask = n_mask;
    #1;
  endtask

  task automatic idle_inputs();
    instrValid_i = 0; excReq_i = '0; excAck_i = 0;
    pc_i = $urandom; instruction_i = $urandom;
`ifdef EXCEPTION_UNIT_MASK_EN
    maskWe_i = 0; maskIn_i = 4'b1111;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_ni = 1;
  endtask

  // Ack the current trap and walk through the release cycle back to idle.
  task automatic release_trap();
    idle_inputs();
    excAck_i = 1;
    #1 tick();
    excAck_i = 0;
    #1 tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({exception_o, halt_o, excCause_o, excPc_o, excInstr_o, excDropped_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: got exc=%0b halt=%0b cause=%0d pc=%h instr=%h drop=%0d, required all zero",
               exception_o, halt_o, excCause_o, excPc_o, excInstr_o, excDropped_o);
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    instrValid_i = 1; excReq_i = 4'b1010; pc_i = 32'h0000_0200; instruction_i = 32'h1234_5678;
    #1;
    checks++;
    if (exception_o !== 1'b1) begin
      errors++; $display("FAIL simul_exception: got %0b required 1", exception_o);
    end
    tick();
    checks++;
    if (excCause_o !== 2'd1 || excCause_o !== m_cause_bits()) begin
      errors++; $display("FAIL simul_cause: got %0d required 1", excCause_o);
    end
    checks++;
    if (excDropped_o !== 4'd0 || halt_o !== 1'b1) begin
      errors++; $display("FAIL simul_drop_halt: got drop=%0d halt=%0b required drop=0 halt=1", excDropped_o, halt_o);
    end
    release_trap();
    checks++;
    if (halt_o !== 1'b0 || exception_o !== 1'b0) begin
      errors++; $display("FAIL simul_released: got halt=%0b exc=%0b required 0 0", halt_o, exception_o);
    end
  endtask

  task automatic test_alu_overflow();
    idle_inputs();
    instrValid_i = 1; excReq_i = 4'b0001; pc_i = 32'h0000_0010; instruction_i = 32'hC2B7_4000;
    #1;
    checks++;
    if (exception_o !== 1'b1 || halt_o !== 1'b0) begin
      errors++; $display("FAIL alu_same_cycle: got exc=%0b halt=%0b required exc=1 halt=0", exception_o, halt_o);
    end
    tick();
    checks++;
    if (halt_o !== 1'b1 || excCause_o !== 2'd0 || excPc_o !== 32'h10 || excInstr_o !== 32'hC2B7_4000) begin
      errors++;
      $display("FAIL alu_capture: got halt=%0b cause=%0d pc=%h instr=%h required 1 0 00000010 c2b74000",
               halt_o, excCause_o, excPc_o, excInstr_o);
    end
  endtask

  task automatic test_stay_halted();
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      pc_i = $urandom; instruction_i = $urandom;
      if (i < 20) begin
        instrValid_i = 1; excReq_i = 4'($urandom_range(1, 15));
      end else if (i % 2 == 1) begin
        instrValid_i = 0; excReq_i = 4'($urandom);
      end else begin
        instrValid_i = 1; excReq_i = 4'b0000;
      end
      #1;
      if (exception_o !== 1'b1) bad++;
      tick();
      if (halt_o !== 1'b1 || excPc_o !== 32'h10 || excInstr_o !== 32'hC2B7_4000 || excCause_o !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stay_halted: got %0d bad cycles required 0", bad);
    end
    checks++;
    if (excDropped_o !== 4'd15 || m_drop != 15) begin
      errors++; $display("FAIL drop_saturate: got %0d required 15", excDropped_o);
    end
  endtask

  task automatic test_release();
    idle_inputs();
    excAck_i = 1;
    #1 tick();
    excAck_i = 0;
    instrValid_i = 1; excReq_i = 4'b0100; pc_i = 32'h0000_0300;
    #1;
    checks++;
    if (halt_o !== 1'b0 || exception_o !== 1'b0) begin
      errors++; $display("FAIL release_cycle: got halt=%0b exc=%0b required 0 0", halt_o, exception_o);
    end
    tick();
    checks++;
    if (halt_o !== 1'b0 || excCause_o !== 2'd0 || excDropped_o !== 4'd15 || excPc_o !== 32'h10) begin
      errors++;
      $display("FAIL release_ignored: got halt=%0b cause=%0d drop=%0d pc=%h required 0 0 15 00000010",
               halt_o, excCause_o, excDropped_o, excPc_o);
    end
    pc_i = 32'h0000_0400; instruction_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (exception_o !== 1'b1) begin
      errors++; $display("FAIL release_rehit_exc: got %0b required 1", exception_o);
    end
    tick();
    checks++;
    if (halt_o !== 1'b1 || excCause_o !== 2'd2 || excPc_o !== 32'h400 || excInstr_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL release_rehit_capture: got halt=%0b cause=%0d pc=%h instr=%h required 1 2 00000400 deadbeef",
               halt_o, excCause_o, excPc_o, excInstr_o);
    end
  endtask

  task automatic test_reset_mid_trap();
    idle_inputs();
    #2 rst_ni = 0;
    model_reset();
    #1;
    checks++;
    if ({exception_o, halt_o, excCause_o, excPc_o, excInstr_o, excDropped_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_trap: got exc=%0b halt=%0b cause=%0d pc=%h instr=%h drop=%0d required all zero",
               exception_o, halt_o, excCause_o, excPc_o, excInstr_o, excDropped_o);
    end
    @(posedge clk_i);
    #3 rst_ni = 1;
    instrValid_i = 1; excReq_i = 4'b1000; pc_i = 32'h0000_0500; instruction_i = 32'hA5A5_0001;
    #1;
    checks++;
    if (exception_o !== 1'b1) begin
      errors++; $display("FAIL post_reset_exc: got %0b required 1", exception_o);
    end
    tick();
    checks++;
    if (halt_o !== 1'b1 || excCause_o !== 2'd3 || excPc_o !== 32'h500 || excDropped_o !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_capture: got halt=%0b cause=%0d pc=%h drop=%0d required 1 3 00000500 0",
               halt_o, excCause_o, excPc_o, excDropped_o);
    end
    release_trap();
  endtask

`ifdef EXCEPTION_UNIT_MASK_EN
  task automatic test_mask();
    idle_inputs();
    maskWe_i = 1; maskIn_i = 4'b1110;
    #1 tick();
    maskWe_i = 0;
    instrValid_i = 1; excReq_i = 4'b0001;
    #1;
    checks++;
    if (exception_o !== 1'b0) begin
      errors++; $display("FAIL mask_blocked: got %0b required 0", exception_o);
    end
    tick();
    excReq_i = 4'b0011; pc_i = 32'h0000_0600;
    #1;
    checks++;
    if (exception_o !== 1'b1) begin
      errors++; $display("FAIL mask_pass_exc: got %0b required 1", exception_o);
    end
    tick();
    checks++;
    if (halt_o !== 1'b1 || excCause_o !== 2'd1) begin
      errors++; $display("FAIL mask_cause: got halt=%0b cause=%0d required 1 1", halt_o, excCause_o);
    end
    release_trap();
    maskWe_i = 1; maskIn_i = 4'b1111;
    #1 tick();
    maskWe_i = 0;
  endtask
`endif

  task automatic test_random();
    int bad_exc = 0;
    int bad_reg = 0;
    for (int i = 0; i < 400; i++) begin
      instrValid_i = 1'($urandom);
      excReq_i = 4'($urandom);
      excAck_i = ($urandom_range(0, 3) == 0);
      pc_i = $urandom; instruction_i = $urandom;
`ifdef EXCEPTION_UNIT_MASK_EN
      maskWe_i = ($urandom_range(0, 15) == 0);
      maskIn_i = 4'($urandom);
`endif
      #1;
      if (exception_o !== m_exception()) begin
        bad_exc++;
        if (bad_exc < 4) $display("FAIL random_exception cycle %0d: got %0b required %0b", i, exception_o, m_exception());
      end
      tick();
      if (halt_o !== m_trapped || excCause_o !== m_cause_bits() || excPc_o !== m_pc ||
          excInstr_o !== m_instr || excDropped_o !== 4'(m_drop)) begin
        bad_reg++;
        if (bad_reg < 4)
          $display("FAIL random_regs cycle %0d: got halt=%0b cause=%0d pc=%h drop=%0d required %0b %0d %h %0d",
                   i, halt_o, excCause_o, excPc_o, excDropped_o, m_trapped, m_cause, m_pc, m_drop);
      end
    end
    checks++;
    if (bad_exc != 0) errors++;
    checks++;
    if (bad_reg != 0) errors++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_simultaneous();
    test_alu_overflow();
    test_stay_halted();
    test_release();
    test_reset_mid_trap();
`ifdef EXCEPTION_UNIT_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
